// File: rtl/ra_uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : ra_uart_rx
// Purpose  : Oversampling 8N1 UART receiver with valid/ready byte output,
//            framing and overrun pulses. Optional parity: UART_RX_PARITY_EN.
// Revision : 1.0
// ============================================================================
module ra_uart_rx #(
    parameter int CLK_HZ = 100000000,
    parameter int BAUD   = 115200,
    parameter int OSR    = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ser_rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun
`ifdef UART_RX_PARITY_EN
    ,
    output logic       parity_err
`endif
);

    localparam int DIV  = CLK_HZ / (BAUD * OSR);
    localparam int c_TW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int c_SW = $clog2(OSR);

    localparam logic [c_TW-1:0] c_T_LAST = c_TW'(DIV - 1);
    localparam logic [c_SW-1:0] c_S_END  = c_SW'(OSR - 1);
    localparam logic [c_SW-1:0] c_S_LO   = c_SW'(OSR / 2 - 1);
    localparam logic [c_SW-1:0] c_S_MID  = c_SW'(OSR / 2);
    localparam logic [c_SW-1:0] c_S_HI   = c_SW'(OSR / 2 + 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_START   = 3'd1,
        S_DATA    = 3'd2,
        S_PARITY  = 3'd3,
        S_STOP    = 3'd4,
        S_WAIT_HI = 3'd5
    } state_t;

    state_t          r_state;
    logic            r_sync1;
    logic            r_sync2;
    logic [c_TW-1:0] r_tcnt;
    logic [c_SW-1:0] r_scnt;
    logic            r_s0;
    logic            r_s1;
    logic            r_s2;
    logic [2:0]      r_bidx;
    logic [7:0]      r_shift;
    logic            r_deliver;
    logic            w_tick;
    logic            w_start;
    logic            w_end;
    logic            w_mid;
    logic            w_maj3;
    logic            w_maj_stop;
    logic            w_par_ok;

`ifdef UART_RX_PARITY_EN
    logic            r_par;
    assign w_par_ok = ~r_par;
`else
    assign w_par_ok = 1'b1;
`endif

    assign w_tick  = (r_tcnt == c_T_LAST);
    assign w_start = (r_state == S_IDLE) && !r_sync2;
    assign w_end   = w_tick && (r_scnt == c_S_END);
    assign w_mid   = w_tick && (r_scnt == c_S_HI);
    assign w_maj3  = (r_s0 & r_s1) | (r_s0 & r_s2) | (r_s1 & r_s2);
    // The stop decision happens on the third sample tick itself, so the
    // live synchronized value stands in for the not-yet-captured r_s2.
    assign w_maj_stop = (r_s0 & r_s1) | (r_s0 & r_sync2) | (r_s1 & r_sync2);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= ser_rx;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || w_start || w_tick) begin
            r_tcnt <= '0;
        end else begin
            r_tcnt <= r_tcnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || (r_state == S_IDLE)) begin
            r_scnt <= '0;
        end else if (w_tick) begin
            r_scnt <= (r_scnt == c_S_END) ? '0 : r_scnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s0 <= 1'b1;
            r_s1 <= 1'b1;
            r_s2 <= 1'b1;
        end else if (w_tick && (r_state != S_IDLE)) begin
            if (r_scnt == c_S_LO)  r_s0 <= r_sync2;
            if (r_scnt == c_S_MID) r_s1 <= r_sync2;
            if (r_scnt == c_S_HI)  r_s2 <= r_sync2;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_bidx    <= 3'd0;
            r_shift   <= 8'h00;
            r_deliver <= 1'b0;
            frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_par      <= 1'b0;
            parity_err <= 1'b0;
`endif
        end else begin
            r_deliver <= 1'b0;
            frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
            case (r_state)
                S_IDLE: begin
                    if (!r_sync2) r_state <= S_START;
                end
                S_START: begin
                    if (w_end) begin
                        if (w_maj3) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_state <= S_DATA;
                            r_bidx  <= 3'd0;
`ifdef UART_RX_PARITY_EN
                            r_par   <= 1'b0;
`endif
                        end
                    end
                end
                S_DATA: begin
                    if (w_end) begin
                        r_shift <= {w_maj3, r_shift[7:1]};
                        r_bidx  <= r_bidx + 3'd1;
`ifdef UART_RX_PARITY_EN
                        r_par   <= r_par ^ w_maj3;
                        if (r_bidx == 3'd7) r_state <= S_PARITY;
`else
                        if (r_bidx == 3'd7) r_state <= S_STOP;
`endif
                    end
                end
`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    if (w_end) begin
                        r_par   <= r_par ^ w_maj3;
                        r_state <= S_STOP;
                    end
                end
`endif
                S_STOP: begin
                    if (w_mid) begin
                        if (w_maj_stop) begin
                            r_deliver <= w_par_ok;
                            r_state   <= S_IDLE;
                        end else begin
                            frame_err <= 1'b1;
                            r_state   <= S_WAIT_HI;
                        end
`ifdef UART_RX_PARITY_EN
                        parity_err <= ~w_par_ok;
`endif
                    end
                end
                S_WAIT_HI: begin
                    if (r_sync2) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // A byte arriving while the holding register is full and not being
    // drained this clock is dropped; the held byte is never overwritten.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_data  <= 8'h00;
            rx_valid <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (r_deliver) begin
                if (!rx_valid || rx_ready) begin
                    rx_data  <= r_shift;
                    rx_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ra_uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_ra_uart_rx
// Purpose  : Directed self-checking bench for ra_uart_rx.
// Revision : 1.0
// ============================================================================
module tb_ra_uart_rx;

    localparam int CLK_HZ = 1600000;
    localparam int BAUD   = 10000;
    localparam int OSR    = 16;
    localparam int DIV    = CLK_HZ / (BAUD * OSR);
    localparam int BIT    = DIV * OSR;
`ifdef UART_RX_PARITY_EN
    localparam int NB      = 10;
    localparam int LAT_LIT = 1704;
`else
    localparam int NB      = 9;
    localparam int LAT_LIT = 1544;
`endif
    // Falling edge driven after edge P0 is seen by the FSM at edge P0+3;
    // the stop decision is OSR/2+1 ticks into the stop bit, ticks every DIV.
    localparam int DEC = 3 + DIV * (OSR * NB + OSR / 2 + 2);

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ser_rx = 1'b1;
    logic       rx_ready = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun;
`ifdef UART_RX_PARITY_EN
    logic       parity_err;
`endif

    ra_uart_rx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .OSR(OSR)) u_dut (
        .clk       (clk),
        .reset     (reset),
        .ser_rx    (ser_rx),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .frame_err (frame_err),
`ifdef UART_RX_PARITY_EN
        .parity_err(parity_err),
`endif
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        int         kind;   // 0 deliver, 1 frame error, 2 parity error
        logic [7:0] d;
    } ev_t;

    ev_t        evq[$];
    int         cyc = 0;
    int         vectors = 0;
    int         miscompares = 0;
    logic       chk_en = 1'b0;
    logic       mv = 1'b0;
    logic [7:0] md = 8'h00;
    logic       mfe = 1'b0;
    logic       mov = 1'b0;
    logic       mpe = 1'b0;
    int         last_p0 = 0;
    int         rises = 0;
    int         rise_cyc = -1;
    logic [7:0] rise_data = 8'h00;
    int         fe_cnt = 0;
    int         ov_cnt = 0;
    int         ov_cyc = -1;
    int         pe_cnt = 0;
    logic       prev_v = 1'b0;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            if (miscompares <= 20)
                $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    // Reference model: byte-level outcomes scheduled per frame, handshake rules applied per clock.
    always @(posedge clk) begin
        logic       dlv;
        logic [7:0] dd;
        cyc++;
        if (reset) begin
            evq.delete();
            mv = 1'b0; md = 8'h00; mfe = 1'b0; mov = 1'b0; mpe = 1'b0;
        end else begin
            mfe = 1'b0; mov = 1'b0; mpe = 1'b0; dlv = 1'b0; dd = 8'h00;
            while (evq.size() > 0 && evq[0].cyc == cyc) begin
                case (evq[0].kind)
                    0: begin dlv = 1'b1; dd = evq[0].d; end
                    1: mfe = 1'b1;
                    default: mpe = 1'b1;
                endcase
                void'(evq.pop_front());
            end
            if (dlv) begin
                if (!mv || rx_ready) begin md = dd; mv = 1'b1; end
                else mov = 1'b1;
            end else if (mv && rx_ready) begin
                mv = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("rx_valid", {7'd0, rx_valid}, {7'd0, mv});
            chk("rx_data", rx_data, md);
            chk("frame_err", {7'd0, frame_err}, {7'd0, mfe});
            chk("overrun", {7'd0, overrun}, {7'd0, mov});
`ifdef UART_RX_PARITY_EN
            chk("parity_err", {7'd0, parity_err}, {7'd0, mpe});
            if (parity_err === 1'b1) pe_cnt++;
`endif
        end
        if (rx_valid === 1'b1 && !prev_v) begin
            rises++; rise_cyc = cyc; rise_data = rx_data;
        end
        prev_v = (rx_valid === 1'b1);
        if (frame_err === 1'b1) fe_cnt++;
        if (overrun === 1'b1) begin ov_cnt++; ov_cyc = cyc; end
    end

    task automatic tick_n(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stopv,
                              input logic parflip, input int kind);
        ev_t e;
        last_p0 = cyc;
        e.d = b;
        e.kind = kind;
        e.cyc = (kind == 0) ? last_p0 + DEC + 1 : last_p0 + DEC;
        if (kind <= 2) evq.push_back(e);
        ser_rx = 1'b0;
        tick_n(BIT);
        for (int i = 0; i < 8; i++) begin
            ser_rx = b[i];
            tick_n(BIT);
        end
`ifdef UART_RX_PARITY_EN
        ser_rx = (^b) ^ parflip;
        tick_n(BIT);
`endif
        ser_rx = stopv;
        tick_n(BIT);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int r0, f0, o0;
        @(posedge clk); #1;
        tick_n(3);
        reset = 1'b0;
        chk_en = 1'b1;
        chk("reset rx_valid", {7'd0, rx_valid}, 8'h00);
        chk("reset rx_data", rx_data, 8'h00);
        chk("reset frame_err", {7'd0, frame_err}, 8'h00);
        chk("reset overrun", {7'd0, overrun}, 8'h00);
        tick_n(50);

        // 1: single byte, consumer always ready
        rx_ready = 1'b1;
        r0 = rises;
        send_frame(8'hA5, 1'b1, 1'b0, 0);
        tick_n(20);
        chk("t1 rises", 8'(rises - r0), 8'd1);
        chk("t1 data", rise_data, 8'hA5);
        chk("t1 latency", 8'(rise_cyc - last_p0 - LAT_LIT), 8'd0);
        chk("t1 valid low", {7'd0, rx_valid}, 8'h00);
        tick_n(BIT);

        // 2: back-to-back frames while consumer stalls
        rx_ready = 1'b0;
        o0 = ov_cnt;
        send_frame(8'h3C, 1'b1, 1'b0, 0);
        send_frame(8'h5A, 1'b1, 1'b0, 0);
        tick_n(2 * BIT);
        chk("t2 valid held", {7'd0, rx_valid}, 8'h01);
        chk("t2 data held", rx_data, 8'h3C);
        chk("t2 overruns", 8'(ov_cnt - o0), 8'd1);
        chk("t2 overrun time", 8'(ov_cyc - last_p0 - LAT_LIT), 8'd0);
        rx_ready = 1'b1;
        tick_n(1);
        chk("t2 valid cleared", {7'd0, rx_valid}, 8'h00);
        tick_n(BIT);

        // 3: short low glitch on idle line, then 0xFF
        r0 = rises; f0 = fe_cnt;
        ser_rx = 1'b0;
        tick_n(40);
        ser_rx = 1'b1;
        tick_n(300);
        chk("t3 no glitch byte", 8'(rises - r0), 8'd0);
        send_frame(8'hFF, 1'b1, 1'b0, 0);
        tick_n(20);
        chk("t3 rises", 8'(rises - r0), 8'd1);
        chk("t3 data", rise_data, 8'hFF);
        chk("t3 no frame_err", 8'(fe_cnt - f0), 8'd0);
        tick_n(BIT);

        // 4: bad stop bit followed by a long break, then 0x42 held
        r0 = rises; f0 = fe_cnt;
        send_frame(8'h81, 1'b0, 1'b0, 1);
        tick_n(2000);
        ser_rx = 1'b1;
        tick_n(3 * BIT);
        chk("t4 one frame_err", 8'(fe_cnt - f0), 8'd1);
        chk("t4 no delivery", 8'(rises - r0), 8'd0);
        rx_ready = 1'b0;
        send_frame(8'h42, 1'b1, 1'b0, 0);
        tick_n(20);
        chk("t4 valid", {7'd0, rx_valid}, 8'h01);
        chk("t4 data", rx_data, 8'h42);

        // 5: reset in the middle of 0x77's data bits, then 0x12
        r0 = rises;
        ser_rx = 1'b0; tick_n(BIT);
        ser_rx = 1'b1; tick_n(BIT);
        ser_rx = 1'b1; tick_n(BIT / 2);
        reset = 1'b1;
        tick_n(1);
        reset = 1'b0;
        chk("t5 valid after reset", {7'd0, rx_valid}, 8'h00);
        chk("t5 data after reset", rx_data, 8'h00);
        tick_n(3 * BIT);
        chk("t5 no partial byte", 8'(rises - r0), 8'd0);
        rx_ready = 1'b1;
        send_frame(8'h12, 1'b1, 1'b0, 0);
        tick_n(20);
        chk("t5 rises", 8'(rises - r0), 8'd1);
        chk("t5 data", rise_data, 8'h12);
        tick_n(BIT);

`ifdef UART_RX_PARITY_EN
        // 6: parity good then parity bad
        r0 = rises; f0 = pe_cnt;
        send_frame(8'h01, 1'b1, 1'b0, 0);
        tick_n(20);
        chk("t6 good parity delivered", 8'(rises - r0), 8'd1);
        chk("t6 good parity data", rise_data, 8'h01);
        send_frame(8'h01, 1'b1, 1'b1, 2);
        tick_n(20);
        chk("t6 bad parity no byte", 8'(rises - r0), 8'd1);
        chk("t6 parity_err pulses", 8'(pe_cnt - f0), 8'd1);
        tick_n(BIT);
`endif

        chk("end queue drained", 8'(evq.size()), 8'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
